// File: rtl/program_counter_pkg.sv
// Shared width and select encodings for the ONC-16 fetch-stage program counter.
// Users of this package: program_counter (optional PC_STALL_EN hold input) and pc_next.
package program_counter_pkg;

    localparam int PC_DATA_W = 16;

    typedef enum logic {
        SEQ = 1'b0,
        BR  = 1'b1
    } br_sel_e;

    typedef enum logic {
        IMM_REL = 1'b0,
        REG_ABS = 1'b1
    } imr_sel_e;

endpackage

// File: rtl/program_counter_pc_next.sv
// Next-PC selection: sequential increment, PC-relative branch, or register-absolute jump.
// All arithmetic is modulo 2^DATA_W with no carry out.
module pc_next
    import program_counter_pkg::*;
#(
    parameter int DATA_W = PC_DATA_W
) (
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs,
    input  logic              imr_sel,
    input  logic              br_sel,
    output logic [DATA_W-1:0] pc_next
);

    logic [DATA_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] w_pc_rel;

    assign w_pc_inc = pc + DATA_W'(1);
    // Offset is applied to the current PC, not PC+1.
    assign w_pc_rel = pc + imm;

    // br_sel is decoded first so imr_sel cannot influence a sequential step.
    always_comb begin
        pc_next = w_pc_inc;
        if (br_sel == BR) begin
            if (imr_sel == REG_ABS) begin
                pc_next = rs;
            end else begin
                pc_next = w_pc_rel;
            end
        end
    end

endmodule

// File: rtl/program_counter.sv
// ONC-16 program counter register driving the instruction-memory address.
// Define PC_STALL_EN to add a stall input that holds the PC (branch requests are dropped).
module program_counter
    import program_counter_pkg::*;
#(
    parameter int DATA_W = PC_DATA_W
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs,
    input  logic              imr_sel,
    input  logic              br_sel,
`ifdef PC_STALL_EN
    input  logic              stall,
`endif
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] w_pc_next;
    logic              w_pc_en;

    pc_next #(
        .DATA_W (DATA_W)
    ) u_pc_next (
        .pc      (r_pc),
        .imm     (imm),
        .rs      (rs),
        .imr_sel (imr_sel),
        .br_sel  (br_sel),
        .pc_next (w_pc_next)
    );

`ifdef PC_STALL_EN
    assign w_pc_en = ~stall;
`else
    assign w_pc_en = 1'b1;
`endif

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_pc <= '0;
        end else if (w_pc_en) begin
            r_pc <= w_pc_next;
        end
    end

    assign out = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter; covers the PC_STALL_EN build when defined.
module tb_program_counter;

    logic        clock;
    logic        n_rst;
    logic [15:0] imm;
    logic [15:0] rs;
    logic        imr_sel;
    logic        br_sel;
    logic        stall;
    logic [15:0] out;

    int n_checks;
    int n_errors;

    program_counter dut (
        .clock   (clock),
        .n_rst   (n_rst),
        .imm     (imm),
        .rs      (rs),
        .imr_sel (imr_sel),
        .br_sel  (br_sel),
`ifdef PC_STALL_EN
        .stall   (stall),
`endif
        .out     (out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: out=0x%04h expected=0x%04h", tag, got, exp);
        end else begin
            $display("ok   %s: out=0x%04h", tag, got);
        end
    endtask

    // Apply inputs just after an edge, then run n rising edges and sample 1 time unit later.
    task automatic step(input logic br, input logic imr, input logic [15:0] imm_v,
                        input logic [15:0] rs_v, input int n);
        br_sel  = br;
        imr_sel = imr;
        imm     = imm_v;
        rs      = rs_v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_rst    = 1'b0;
        imm      = 16'h0000;
        rs       = 16'h0000;
        imr_sel  = 1'b0;
        br_sel   = 1'b0;
        stall    = 1'b0;

        #12;
        check_val("reset_state", out, 16'h0000);
        n_rst = 1'b1;

        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1);
        check_val("first_edge", out, 16'h0001);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 99);
        check_val("count_100", out, 16'h0064);

        step(1'b0, 1'b1, 16'h0000, 16'hFFFF, 100);
        check_val("imr_ignored", out, 16'h00C8);

        step(1'b0, 1'bx, 16'h1234, 16'hABCD, 2);
        check_val("imr_x_seq", out, 16'h00CA);

        // Asynchronous reset between edges.
        #3 n_rst = 1'b0;
        #1 check_val("async_reset", out, 16'h0000);
        @(posedge clock); #1;
        check_val("reset_held", out, 16'h0000);
        #2 n_rst = 1'b1;

        step(1'b1, 1'b1, 16'h0000, 16'h0100, 1);
        check_val("jump_0100", out, 16'h0100);

        // Inputs change mid-cycle; out must not follow combinationally.
        br_sel = 1'b1; imr_sel = 1'b1; rs = 16'h7777;
        #2 check_val("no_comb_path", out, 16'h0100);

        step(1'b1, 1'b0, 16'h0080, 16'h7777, 1);
        check_val("rel_plus_80", out, 16'h0180);
        step(1'b0, 1'b0, 16'h0080, 16'h0000, 10);
        check_val("seq_after_rel", out, 16'h018A);
        step(1'b1, 1'b0, 16'hFFF0, 16'h0000, 1);
        check_val("rel_minus_16", out, 16'h017A);
        step(1'b1, 1'b0, 16'hFFF0, 16'h0000, 1);
        check_val("rel_accumulate", out, 16'h016A);

        step(1'b1, 1'b1, 16'h0000, 16'h8000, 1);
        check_val("jump_8000", out, 16'h8000);
        step(1'b0, 1'b0, 16'h0000, 16'h8000, 3);
        check_val("inc_after_jump", out, 16'h8003);
        step(1'b1, 1'b1, 16'h0000, 16'hFFFF, 2);
        check_val("jump_hold_ffff", out, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1);
        check_val("wrap_to_0", out, 16'h0000);

        step(1'b1, 1'b1, 16'h0000, 16'h0005, 1);
        check_val("jump_0005", out, 16'h0005);
        step(1'b1, 1'b0, 16'hFFF0, 16'h0000, 1);
        check_val("neg_wrap", out, 16'hFFF5);
        step(1'b1, 1'b0, 16'h0010, 16'h0000, 1);
        check_val("pos_wrap", out, 16'h0005);

`ifdef PC_STALL_EN
        stall = 1'b1;
        step(1'b1, 1'b1, 16'h0000, 16'h1234, 3);
        check_val("stall_hold", out, 16'h0005);
        stall = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 16'h1234, 1);
        check_val("stall_resume", out, 16'h0006);
        stall = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1);
        check_val("stall_seq_hold", out, 16'h0006);
        #3 n_rst = 1'b0;
        #1 check_val("reset_over_stall", out, 16'h0000);
        #2 n_rst = 1'b1;
        stall = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1);
        check_val("restart_after_stall", out, 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
